// File: rtl/main_dispatcher.sv
// Block dispatcher: hands out C_ij block indexes row-major to the lowest free CU and tracks completion.
// Optional result counter output o_Result_Count is enabled by defining DISPATCH_STATS_EN.
module main_dispatcher #(
  parameter int NUM_CU      = 4,
  parameter int index_width = 8
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Start,
  input  logic [index_width-1:0] i_Block_Count,
  input  logic [NUM_CU-1:0]      i_Indexes_Received,
  input  logic [NUM_CU-1:0]      i_Result_Ready,
  output logic [index_width-1:0] o_Row_Index,
  output logic [index_width-1:0] o_Column_Index,
  output logic [NUM_CU-1:0]      o_Indexes_Ready,
  output logic                   o_Busy,
  output logic                   o_Done
`ifdef DISPATCH_STATS_EN
  ,
  output logic [2*index_width-1:0] o_Result_Count
`endif
);

  localparam int SEL_W = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

  typedef enum logic [2:0] {
    s_Idle,
    s_Find_Free,
    s_Dispatch,
    s_Drain,
    s_Done
  } t_State;

  t_State                 r_State;
  logic [NUM_CU-1:0]      r_Busy_Vec;
  logic [SEL_W-1:0]       r_Sel;
  logic [index_width-1:0] r_Row;
  logic [index_width-1:0] r_Col;
  logic [index_width-1:0] r_Count;
  logic [NUM_CU-1:0]      r_Indexes_Ready;
  logic                   r_Busy;
  logic                   r_Done;

  logic [SEL_W-1:0]       w_Free_Idx;
  logic                   w_Any_Free;
  logic                   w_Ack;
  logic [NUM_CU-1:0]      w_One;
  logic [NUM_CU-1:0]      w_Sel_Mask;
  logic [NUM_CU-1:0]      w_Free_Mask;
  logic [NUM_CU-1:0]      w_Set;
  logic [NUM_CU-1:0]      w_Accept;
  logic [NUM_CU-1:0]      w_Busy_Next;
  logic [index_width-1:0] w_Last_Idx;
  logic                   w_Last_Col;
  logic                   w_Last_Block;

  // Lowest-numbered free CU wins: scan downward so the smallest index is assigned last.
  always_comb begin
    w_Free_Idx = '0;
    w_Any_Free = 1'b0;
    for (int i = NUM_CU - 1; i >= 0; i--) begin
      if (!r_Busy_Vec[i]) begin
        w_Free_Idx = SEL_W'(i);
        w_Any_Free = 1'b1;
      end
    end
  end

  assign w_One        = {{(NUM_CU-1){1'b0}}, 1'b1};
  assign w_Sel_Mask   = w_One << r_Sel;
  assign w_Free_Mask  = w_One << w_Free_Idx;
  assign w_Ack        = (r_State == s_Dispatch) && i_Indexes_Received[r_Sel];
  assign w_Set        = w_Ack ? w_Sel_Mask : '0;

  // A result coinciding with a fresh acknowledge on the same CU is stale; the new set wins.
  assign w_Accept     = (r_State != s_Idle) ? (i_Result_Ready & r_Busy_Vec & ~w_Set) : '0;
  assign w_Busy_Next  = (r_Busy_Vec & ~w_Accept) | w_Set;

  assign w_Last_Idx   = r_Count - {{(index_width-1){1'b0}}, 1'b1};
  assign w_Last_Col   = (r_Col == w_Last_Idx);
  assign w_Last_Block = w_Last_Col && (r_Row == w_Last_Idx);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_State         <= s_Idle;
      r_Busy_Vec      <= '0;
      r_Sel           <= '0;
      r_Row           <= '0;
      r_Col           <= '0;
      r_Count         <= '0;
      r_Indexes_Ready <= '0;
      r_Busy          <= 1'b0;
      r_Done          <= 1'b0;
    end else begin
      r_Done     <= 1'b0;
      r_Busy_Vec <= w_Busy_Next;
      case (r_State)
        s_Idle: begin
          if (i_Start) begin
            r_Count <= i_Block_Count;
            r_Row   <= '0;
            r_Col   <= '0;
            r_Busy  <= 1'b1;
            r_State <= (i_Block_Count == '0) ? s_Done : s_Find_Free;
          end
        end
        s_Find_Free: begin
          if (w_Any_Free) begin
            r_Sel           <= w_Free_Idx;
            r_Indexes_Ready <= w_Free_Mask;
            r_State         <= s_Dispatch;
          end
        end
        s_Dispatch: begin
          if (w_Ack) begin
            r_Indexes_Ready <= '0;
            if (w_Last_Block) begin
              r_State <= s_Drain;
            end else begin
              r_State <= s_Find_Free;
              if (w_Last_Col) begin
                r_Col <= '0;
                r_Row <= r_Row + {{(index_width-1){1'b0}}, 1'b1};
              end else begin
                r_Col <= r_Col + {{(index_width-1){1'b0}}, 1'b1};
              end
            end
          end
        end
        s_Drain: begin
          if (r_Busy_Vec == '0) r_State <= s_Done;
        end
        s_Done: begin
          r_Done  <= 1'b1;
          r_Busy  <= 1'b0;
          r_State <= s_Idle;
        end
        default: r_State <= s_Idle;
      endcase
    end
  end

  assign o_Row_Index     = r_Row;
  assign o_Column_Index  = r_Col;
  assign o_Indexes_Ready = r_Indexes_Ready;
  assign o_Busy          = r_Busy;
  assign o_Done          = r_Done;

`ifdef DISPATCH_STATS_EN
  logic [2*index_width-1:0] r_Result_Count;
  logic [2*index_width-1:0] w_Accept_Cnt;

  always_comb begin
    w_Accept_Cnt = '0;
    for (int i = 0; i < NUM_CU; i++) begin
      w_Accept_Cnt = w_Accept_Cnt + {{(2*index_width-1){1'b0}}, w_Accept[i]};
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_Result_Count <= '0;
    end else if (r_State == s_Idle && i_Start) begin
      r_Result_Count <= '0;
    end else begin
      r_Result_Count <= r_Result_Count + w_Accept_Cnt;
    end
  end

  assign o_Result_Count = r_Result_Count;
`endif

endmodule

// File: tb/tb_main_dispatcher.sv
// Directed bench for main_dispatcher: a small CU responder model drives acks/results and logs offers.
// Stats-counter checks are compiled only when DISPATCH_STATS_EN is defined.
module tb_main_dispatcher;

  localparam int NCU = 4;
  localparam int IW  = 8;

  bit              clk = 1'b0;
  logic            i_Reset;
  logic            i_Start;
  logic [IW-1:0]   i_Block_Count;
  logic [NCU-1:0]  i_Indexes_Received;
  logic [NCU-1:0]  i_Result_Ready;
  logic [IW-1:0]   o_Row_Index;
  logic [IW-1:0]   o_Column_Index;
  logic [NCU-1:0]  o_Indexes_Ready;
  logic            o_Busy;
  logic            o_Done;
`ifdef DISPATCH_STATS_EN
  logic [2*IW-1:0] o_Result_Count;
`endif

  main_dispatcher #(.NUM_CU(NCU), .index_width(IW)) dut (
    .i_Clock            (clk),
    .i_Reset            (i_Reset),
    .i_Start            (i_Start),
    .i_Block_Count      (i_Block_Count),
    .i_Indexes_Received (i_Indexes_Received),
    .i_Result_Ready     (i_Result_Ready),
    .o_Row_Index        (o_Row_Index),
    .o_Column_Index     (o_Column_Index),
    .o_Indexes_Ready    (o_Indexes_Ready),
    .o_Busy             (o_Busy),
    .o_Done             (o_Done)
`ifdef DISPATCH_STATS_EN
    ,
    .o_Result_Count     (o_Result_Count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ack_delay;
  int res_delay;
  bit auto_res;
  int off_t [NCU];
  int res_t [NCU];
  logic [NCU-1:0] ready_seen;
  int log_cu [$];
  int log_row[$];
  int log_col[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < NCU; c++) begin
      off_t[c] = 0;
      res_t[c] = 0;
    end
    i_Indexes_Received = '0;
    i_Result_Ready     = '0;
    log_cu.delete();
    log_row.delete();
    log_col.delete();
    ready_seen = '0;
  endtask

  // One clock: log handshakes seen before the edge, then compute CU responses for the next cycle.
  task automatic tick();
    for (int c = 0; c < NCU; c++) begin
      if (o_Indexes_Ready[c] && i_Indexes_Received[c]) begin
        log_cu.push_back(c);
        log_row.push_back(int'(o_Row_Index));
        log_col.push_back(int'(o_Column_Index));
        if (auto_res) res_t[c] = res_delay;
      end
    end
    ready_seen = ready_seen | o_Indexes_Ready;
    @(posedge clk);
    #1;
    if (o_Done) done_cnt++;
    i_Result_Ready     = '0;
    i_Indexes_Received = '0;
    for (int c = 0; c < NCU; c++) begin
      if (res_t[c] > 0) begin
        res_t[c]--;
        if (res_t[c] == 0) i_Result_Ready[c] = 1'b1;
      end
      if (o_Indexes_Ready[c]) begin
        off_t[c]++;
        if (off_t[c] > ack_delay) i_Indexes_Received[c] = 1'b1;
      end else begin
        off_t[c] = 0;
      end
    end
  endtask

  task automatic start_run(input int count);
    i_Block_Count = IW'(count);
    i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk(tag, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_idle"}, {63'd0, o_Busy}, 64'd0);
  endtask

  task automatic wait_log(input int size, input int budget, input string tag);
    int n;
    n = 0;
    while (log_cu.size() < size && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(log_cu.size() >= size), 64'd1);
  endtask

  function automatic int log_at(input int which, input int idx);
    if (idx >= log_cu.size()) return -1;
    case (which)
      0:       return log_cu[idx];
      1:       return log_row[idx];
      default: return log_col[idx];
    endcase
  endfunction

  task automatic chk_offer(input string tag, input int idx, input int cu, input int row, input int col);
    chk({tag, "_cu"},  64'(log_at(0, idx)), 64'(cu));
    chk({tag, "_row"}, 64'(log_at(1, idx)), 64'(row));
    chk({tag, "_col"}, 64'(log_at(2, idx)), 64'(col));
  endtask

  initial begin
    i_Reset = 1'b1;
    i_Start = 1'b0;
    i_Block_Count = '0;
    ack_delay = 0;
    res_delay = 1;
    auto_res  = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(o_Indexes_Ready), 64'd0);
    chk("rst_busy",  {63'd0, o_Busy}, 64'd0);
    chk("rst_done",  {63'd0, o_Done}, 64'd0);
    chk("rst_row",   64'(o_Row_Index), 64'd0);
    chk("rst_col",   64'(o_Column_Index), 64'd0);
    i_Reset = 1'b0;
    tick();

    // Four blocks onto four CUs, ack one cycle after offer, results ten cycles later.
    clear_model();
    ack_delay = 1; auto_res = 1'b1; res_delay = 10;
    start_run(2);
    chk("t1_busy", {63'd0, o_Busy}, 64'd1);
    run_until_done(200, "t1_done");
    chk("t1_nlog", 64'(log_cu.size()), 64'd4);
    chk_offer("t1_o0", 0, 0, 0, 0);
    chk_offer("t1_o1", 1, 1, 0, 1);
    chk_offer("t1_o2", 2, 2, 1, 0);
    chk_offer("t1_o3", 3, 3, 1, 1);

    // count=3 with all CUs held busy; CU2's result frees it for the next block.
    clear_model();
    ack_delay = 0; auto_res = 1'b0;
    start_run(3);
    wait_log(4, 60, "t2_fill");
    repeat (5) tick();
    chk("t2_stall_nlog", 64'(log_cu.size()), 64'd4);
    chk("t2_stall_ready", 64'(o_Indexes_Ready), 64'd0);
    chk_offer("t2_o2", 2, 2, 0, 2);
    chk_offer("t2_o3", 3, 3, 1, 0);
    i_Result_Ready = 4'b0100;
    tick();
    wait_log(5, 20, "t2_free");
    chk_offer("t2_o4", 4, 2, 1, 1);
    auto_res = 1'b1; res_delay = 3;
    i_Result_Ready = 4'b1111;
    run_until_done(200, "t2_done");
    chk("t2_nlog", 64'(log_cu.size()), 64'd9);
    chk("t2_o5", 64'((log_at(1, 5) << 8) | log_at(2, 5)), 64'h0102);
    chk("t2_o6", 64'((log_at(1, 6) << 8) | log_at(2, 6)), 64'h0200);
    chk("t2_o8", 64'((log_at(1, 8) << 8) | log_at(2, 8)), 64'h0202);

    // Zero-block request completes without any offer.
    clear_model();
    start_run(0);
    chk("t3_done_e1", {63'd0, o_Done}, 64'd0);
    chk("t3_busy_e1", {63'd0, o_Busy}, 64'd1);
    tick();
    chk("t3_done_e2", {63'd0, o_Done}, 64'd1);
    chk("t3_busy_e2", {63'd0, o_Busy}, 64'd0);
    tick();
    chk("t3_done_e3", {63'd0, o_Done}, 64'd0);
    chk("t3_no_offer", 64'(ready_seen), 64'd0);

    // Slow ack: offer held steady for five cycles; a Start during the run has no effect.
    clear_model();
    ack_delay = 5; auto_res = 1'b1; res_delay = 2;
    start_run(1);
    for (int n = 0; n < 20 && o_Indexes_Ready == '0; n++) tick();
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_ready", 64'(o_Indexes_Ready), 64'd1);
      chk("t4_hold_idx", 64'({o_Row_Index, o_Column_Index}), 64'd0);
      if (i == 2) begin
        i_Block_Count = 8'd7;
        i_Start = 1'b1;
      end
      tick();
      i_Start = 1'b0;
    end
    run_until_done(100, "t4_done");
    chk("t4_nlog", 64'(log_cu.size()), 64'd1);

    // Reset in the middle of the third dispatch, then a clean one-block run.
    clear_model();
    ack_delay = 0; auto_res = 1'b0;
    start_run(2);
    for (int n = 0; n < 30 && !(log_cu.size() >= 2 && o_Indexes_Ready != '0); n++) tick();
    chk("t5_pre_row", 64'(o_Row_Index), 64'd1);
    #2;
    i_Reset = 1'b1;
    #1;
    chk("t5_rst_ready", 64'(o_Indexes_Ready), 64'd0);
    chk("t5_rst_busy",  {63'd0, o_Busy}, 64'd0);
    chk("t5_rst_done",  {63'd0, o_Done}, 64'd0);
    chk("t5_rst_idx",   64'({o_Row_Index, o_Column_Index}), 64'd0);
    clear_model();
    @(posedge clk);
    #1;
    i_Reset = 1'b0;
    ack_delay = 1; auto_res = 1'b1; res_delay = 2;
    start_run(1);
    chk("t5_accept", {63'd0, o_Busy}, 64'd1);
    run_until_done(100, "t5_done");
    chk("t5_nlog", 64'(log_cu.size()), 64'd1);
    chk_offer("t5_o0", 0, 0, 0, 0);

`ifdef DISPATCH_STATS_EN
    // Spurious result on a CU that is not busy must not be counted.
    clear_model();
    ack_delay = 0; auto_res = 1'b1; res_delay = 4;
    start_run(2);
    chk("t6_clr", 64'(o_Result_Count), 64'd0);
    i_Result_Ready = 4'b1000;
    run_until_done(200, "t6_done");
    chk("t6_count", 64'(o_Result_Count), 64'd4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
